// File: rtl/rgb_pwm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_pkg
//  Description : Shared constants and types for the rgb_pwm block: register
//                address map, ctrl register bit positions, fade FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb_pwm_pkg;

    // Register address map seen on wr_addr
    localparam logic [1:0] ADDR_R    = 2'd0;
    localparam logic [1:0] ADDR_G    = 2'd1;
    localparam logic [1:0] ADDR_B    = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    // ctrl register layout; bits [3:2] are accepted but carry no function
    localparam int CTRL_TEST     = 0;
    localparam int CTRL_FADE     = 1;
    localparam int CTRL_RATE_LSB = 4;

    // Fade engine states
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_FADE = 1'b1
    } fade_state_e;

endpackage : rgb_pwm_pkg
`default_nettype wire

// File: rtl/rgb_pwm_channel.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_channel
//  Description : One colour channel: target and current intensity, the
//                period-aligned shadow duty, one fade step and the PWM compare.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic [7:0] pwm_cnt_next,  // value pwm_cnt takes on this edge
    input  logic       period_end,
    input  logic       step_en,
    input  logic       fade_en,
    input  logic       wr_en,         // already decoded for this channel
    input  logic [7:0] wr_data,
    output logic       pwm,
    output logic       neq            // next cur differs from next target
);

    logic [7:0] target_q, target_d;
    logic [7:0] cur_q,    cur_d;
    logic [7:0] active_q, active_d;
    logic       pwm_q,    pwm_d;

    // Next-state for target, current intensity, shadow duty and PWM output
    always_comb begin
        target_d = target_q;
        cur_d    = cur_q;
        active_d = active_q;

        // The fade step compares against the pre-write target, so a write on
        // the same edge only becomes effective from the following cycle.
        if (fade_en) begin
            if (step_en) begin
                if (cur_q < target_q) begin
                    cur_d = cur_q + 8'd1;
                end else if (cur_q > target_q) begin
                    cur_d = cur_q - 8'd1;
                end
            end
        end else begin
            // Without fading the current value tracks the target, which also
            // snaps an interrupted fade to its end point.
            cur_d = target_q;
        end

        if (wr_en) begin
            target_d = wr_data;
            if (!fade_en) begin
                cur_d = wr_data;
            end
        end

        // Shadow takes the pre-write, pre-step current value at period end
        if (period_end) begin
            active_d = cur_q;
        end

        // Compare against next-cycle counter so pwm aligns with pwm_cnt
        pwm_d = (active_d > pwm_cnt_next);
        neq   = (cur_d != target_d);
    end

    // Channel state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            target_q <= 8'd0;
            cur_q    <= 8'd0;
            active_q <= 8'd0;
            pwm_q    <= 1'b0;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule : rgb_pwm_channel
`default_nettype wire

// File: rtl/rgb_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm
//  Description : Three-channel 8-bit PWM generator with shadowed duties,
//                ctrl register and an optional linear fade engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 4
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       pwm_r,
    output logic       pwm_g,
    output logic       pwm_b,
    output logic       test_mode,
    output logic       busy,
    output logic       period_start
);

    localparam int                 PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [3:0]         fade_cnt_q, fade_cnt_d;
    logic               test_mode_q, test_mode_d;
    logic               fade_en_q, fade_en_d;
    logic [3:0]         fade_rate_q, fade_rate_d;
    logic               busy_q, busy_d;
    logic               period_start_q, period_start_d;
    fade_state_e        state_q, state_d;

    logic tick;
    logic period_end;
    logic step_en;
    logic neq_r, neq_g, neq_b;

    // Prescaler, PWM counter, ctrl register and registered status outputs
    always_comb begin
        tick           = (presc_q == PRESC_MAX);
        presc_d        = tick ? '0 : presc_q + PRESC_W'(1);
        pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        period_end     = tick && (pwm_cnt_q == 8'hFF);
        period_start_d = period_end;

        test_mode_d = test_mode_q;
        fade_en_d   = fade_en_q;
        fade_rate_d = fade_rate_q;
        if (wr_en && (wr_addr == ADDR_CTRL)) begin
            test_mode_d = wr_data[CTRL_TEST];
            fade_en_d   = wr_data[CTRL_FADE];
            fade_rate_d = wr_data[CTRL_RATE_LSB +: 4];
        end

        busy_d = neq_r | neq_g | neq_b;
    end

    // Fade FSM: busy_q reflects cur != target for the present cycle
    always_comb begin
        state_d    = state_q;
        fade_cnt_d = fade_cnt_q;
        step_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                fade_cnt_d = 4'd0;
                if (fade_en_q && busy_q) begin
                    state_d = S_FADE;
                end
            end
            S_FADE: begin
                if (!fade_en_q || !busy_q) begin
                    state_d    = S_IDLE;
                    fade_cnt_d = 4'd0;
                end else if (period_end) begin
                    if (fade_cnt_q == fade_rate_q) begin
                        fade_cnt_d = 4'd0;
                        step_en    = 1'b1;
                    end else begin
                        fade_cnt_d = fade_cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d    = S_IDLE;
                fade_cnt_d = 4'd0;
            end
        endcase
    end

    // Top-level state registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            presc_q        <= '0;
            pwm_cnt_q      <= 8'd0;
            fade_cnt_q     <= 4'd0;
            test_mode_q    <= 1'b0;
            fade_en_q      <= 1'b0;
            fade_rate_q    <= 4'd0;
            busy_q         <= 1'b0;
            period_start_q <= 1'b0;
            state_q        <= S_IDLE;
        end else begin
            presc_q        <= presc_d;
            pwm_cnt_q      <= pwm_cnt_d;
            fade_cnt_q     <= fade_cnt_d;
            test_mode_q    <= test_mode_d;
            fade_en_q      <= fade_en_d;
            fade_rate_q    <= fade_rate_d;
            busy_q         <= busy_d;
            period_start_q <= period_start_d;
            state_q        <= state_d;
        end
    end

    rgb_pwm_channel u_ch_r (
        .clk          (clk),
        .nrst         (nrst),
        .pwm_cnt_next (pwm_cnt_d),
        .period_end   (period_end),
        .step_en      (step_en),
        .fade_en      (fade_en_q),
        .wr_en        (wr_en && (wr_addr == ADDR_R)),
        .wr_data      (wr_data),
        .pwm          (pwm_r),
        .neq          (neq_r)
    );

    rgb_pwm_channel u_ch_g (
        .clk          (clk),
        .nrst         (nrst),
        .pwm_cnt_next (pwm_cnt_d),
        .period_end   (period_end),
        .step_en      (step_en),
        .fade_en      (fade_en_q),
        .wr_en        (wr_en && (wr_addr == ADDR_G)),
        .wr_data      (wr_data),
        .pwm          (pwm_g),
        .neq          (neq_g)
    );

    rgb_pwm_channel u_ch_b (
        .clk          (clk),
        .nrst         (nrst),
        .pwm_cnt_next (pwm_cnt_d),
        .period_end   (period_end),
        .step_en      (step_en),
        .fade_en      (fade_en_q),
        .wr_en        (wr_en && (wr_addr == ADDR_B)),
        .wr_data      (wr_data),
        .pwm          (pwm_b),
        .neq          (neq_b)
    );

    assign test_mode    = test_mode_q;
    assign busy         = busy_q;
    assign period_start = period_start_q;

endmodule : rgb_pwm
`default_nettype wire

// File: tb/tb_rgb_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb_pwm
//  Description : Directed self-checking bench for rgb_pwm with PRESCALE=1
//                (one PWM count per clk, 256-cycle period).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb_pwm;

    logic       clk     = 1'b0;
    logic       nrst    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] wr_data = 8'd0;
    logic       pwm_r, pwm_g, pwm_b, test_mode, busy, period_start;

    int checks   = 0;
    int failures = 0;

    // Per-period measurement results
    int hi_r, hi_g, hi_b;
    int fl_r, fl_g, fl_b;
    int ps_cnt, busy0, busy_any;
    int wait_n, wait_hr;

    rgb_pwm #(.PRESCALE(1)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .test_mode    (test_mode),
        .busy         (busy),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Advance to the next sample where period_start is high; counts pwm_r
    // highs seen on the way.
    task automatic wait_ps();
        wait_n  = 0;
        wait_hr = 0;
        while (period_start !== 1'b1 && wait_n < 600) begin
            if (pwm_r === 1'b1) wait_hr++;
            @(negedge clk);
            wait_n++;
        end
        chk("period_start_seen", period_start, 1);
    endtask

    // Measure one full period starting at a period_start sample; leaves the
    // bench at the following period_start sample.
    task automatic meas();
        hi_r = 0; hi_g = 0; hi_b = 0;
        fl_r = 256; fl_g = 256; fl_b = 256;
        ps_cnt = 0; busy0 = 0; busy_any = 0;
        for (int k = 0; k < 256; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) busy0 = (busy === 1'b1) ? 1 : 0;
            if (busy === 1'b1) busy_any = 1;
            if (period_start === 1'b1) ps_cnt++;
            if (pwm_r === 1'b1) hi_r++; else if (fl_r == 256) fl_r = k;
            if (pwm_g === 1'b1) hi_g++; else if (fl_g == 256) fl_g = k;
            if (pwm_b === 1'b1) hi_b++; else if (fl_b == 256) fl_b = k;
        end
        @(negedge clk);
    endtask

    // After a reset release: outputs quiet, period_start at 256 and 512
    task automatic idle_window(input string tag);
        int first_ps, second_ps, pulses, active_out;
        first_ps = -1; second_ps = -1; pulses = 0; active_out = 0;
        for (int i = 1; i <= 600; i++) begin
            @(negedge clk);
            if (period_start === 1'b1) begin
                pulses++;
                if (first_ps < 0) first_ps = i;
                else if (second_ps < 0) second_ps = i;
            end
            if ((pwm_r | pwm_g | pwm_b | busy | test_mode) !== 1'b0) active_out++;
        end
        chk({tag, "_first_ps"}, first_ps, 256);
        chk({tag, "_second_ps"}, second_ps, 512);
        chk({tag, "_pulses"}, pulses, 2);
        chk({tag, "_outputs_quiet"}, active_out, 0);
    endtask

    initial begin
        // 1: reset, then quiet periods
        repeat (3) @(negedge clk);
        chk("reset_outputs", {pwm_r, pwm_g, pwm_b, test_mode, busy, period_start}, 6'd0);
        nrst = 1'b1;
        idle_window("t1");

        // 2: R=0x40 mid-period, shadowed until the next period
        wr(2'd0, 8'h40);
        wait_ps();
        chk("t2_cur_period_r_hi", wait_hr, 0);
        meas();
        chk("t2_p1_r_hi", hi_r, 64);
        chk("t2_p1_r_first_low", fl_r, 64);
        meas();
        chk("t2_p2_r_hi", hi_r, 64);
        chk("t2_p2_ps_pulses", ps_cnt, 1);

        // 3: G full scale, B zero, no fade
        wr(2'd1, 8'hFF);
        wr(2'd2, 8'h00);
        chk("t3_busy_after_wr", busy, 0);
        wait_ps();
        meas();
        chk("t3_g_hi", hi_g, 255);
        chk("t3_g_first_low", fl_g, 255);
        chk("t3_b_hi", hi_b, 0);
        chk("t3_r_hi", hi_r, 64);
        chk("t3_busy_any", busy_any, 0);

        // 4: fade rate 0, G 0 -> 4
        wr(2'd1, 8'h00);
        wr(2'd3, 8'h02);
        chk("t4_busy_before", busy, 0);
        wr(2'd1, 8'h04);
        chk("t4_busy_rise", busy, 1);
        wait_ps();
        for (int p = 0; p < 5; p++) begin
            meas();
            chk($sformatf("t4_p%0d_g_hi", p + 1), hi_g, p);
            chk($sformatf("t4_p%0d_busy_start", p + 1), busy0, (p < 3) ? 1 : 0);
        end

        // 5: fade rate 1, R 0 -> 2, fade cancelled midway
        wr(2'd3, 8'h00);
        wr(2'd0, 8'h00);
        wr(2'd3, 8'h12);
        wr(2'd0, 8'h02);
        chk("t5_busy_rise", busy, 1);
        wait_ps();
        meas();
        chk("t5_p1_r_hi", hi_r, 0);
        meas();
        chk("t5_p2_r_hi", hi_r, 0);
        chk("t5_p3_busy_start", busy, 1);
        chk("t5_test_mode_0", test_mode, 0);
        wr(2'd3, 8'h00);
        chk("t5_busy_still_high", busy, 1);
        @(negedge clk);
        chk("t5_busy_drop", busy, 0);
        wait_ps();
        meas();
        chk("t5_p4_r_hi_snapped", hi_r, 2);
        chk("t5_test_mode_still_0", test_mode, 0);
        wr(2'd3, 8'h01);
        chk("t5_test_mode_1", test_mode, 1);

        // 6: asynchronous reset mid-fade, on the first cycle of a period
        wr(2'd3, 8'h03);
        wr(2'd2, 8'h80);
        chk("t6_busy_pre", busy, 1);
        wait_ps();
        chk("t6_pre_outputs", {pwm_r, pwm_g, test_mode, busy}, 4'hF);
        #1 nrst = 1'b0;
        #1;
        chk("t6_async_outputs", {pwm_r, pwm_g, pwm_b, test_mode, busy, period_start}, 6'd0);
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        idle_window("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rgb_pwm
`default_nettype wire
